// File: rtl/regfile_pkg.sv
// Shared constants for the zero-register file: default geometry,
// the hardwired register index and the write-counter limits.
package regfile_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned ZERO_IDX  = 0;
  localparam int unsigned CNT_W     = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: array select, optional write-through
// forwarding, and forcing of the hardwired zero register.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter bit          BYPASS = 1'b0
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic [ADDR_W-1:0]           raddr_i,
  input  logic                        fwd_en_i,
  input  logic [ADDR_W-1:0]           waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic [WIDTH-1:0]            rdata_o
);

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);

  // Zero-forcing is applied last so it wins over forwarding.
  always_comb begin
    rdata_o = regs_i[raddr_i];
    if (BYPASS && fwd_en_i && (raddr_i == waddr_i)) begin
      rdata_o = wdata_i;
    end
    if (raddr_i == ZADDR) begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/regfile_zero.sv
// Two-read/one-write register file with r0 hardwired to zero.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module regfile_zero
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  output logic              zero_wr_err,
  output logic [15:0]       wr_count
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic [DEPTH-1:0][WIDTH-1:0] regs_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic                        err_q;
  logic                        err_d;
  logic                        commit;
  logic                        zero_hit;
  logic                        fwd_en;

  assign zero_hit = we && (waddr == ZADDR);
  assign commit   = we && (waddr != ZADDR);
  assign fwd_en   = commit && rst_n;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (commit) begin
      regs_d[waddr] = wdata;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (zero_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rd1 (
    .regs_i  (regs_q),
    .raddr_i (raddr1),
    .fwd_en_i(fwd_en),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata1)
  );

  regfile_rdport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rd2 (
    .regs_i  (regs_q),
    .raddr_i (raddr2),
    .fwd_en_i(fwd_en),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata2)
  );

  assign zero_wr_err = err_q;
  assign wr_count    = cnt_q;

endmodule

// File: tb/tb_regfile_zero.sv
// Directed bench for regfile_zero: reset, writes, r0 protection,
// same-cycle read behaviour, reset priority and counter saturation.
module tb_regfile_zero;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        zero_wr_err;
  logic [15:0] wr_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_zero dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .zero_wr_err(zero_wr_err),
    .wr_count   (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp7;

    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state on every address, both ports.
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(31 - a);
      #1;
      chk($sformatf("rst_rd1_a%0d", a), rdata1, 32'h0);
      chk($sformatf("rst_rd2_a%0d", 31 - a), rdata2, 32'h0);
    end
    chk("rst_cnt", {16'h0, wr_count}, 32'h0);
    chk("rst_err", {31'h0, zero_wr_err}, 32'h0);

    // Write r5 and read on both ports.
    we    = 1'b1;
    waddr = 5'd5;
    wdata = 32'hDEADBEEF;
    step();
    we     = 1'b0;
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    #1;
    chk("r5_rd1", rdata1, 32'hDEADBEEF);
    chk("r5_rd2", rdata2, 32'hDEADBEEF);
    chk("r5_cnt", {16'h0, wr_count}, 32'd1);

    // Write to r0 is discarded and flagged.
    we    = 1'b1;
    waddr = 5'd0;
    wdata = 32'h12345678;
    step();
    we     = 1'b0;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    chk("r0_rd1", rdata1, 32'h0);
    chk("r0_rd2", rdata2, 32'h0);
    chk("r0_err", {31'h0, zero_wr_err}, 32'h1);
    chk("r0_cnt", {16'h0, wr_count}, 32'd1);

    // r7 = 1, then same-cycle write/read of r7.
    we    = 1'b1;
    waddr = 5'd7;
    wdata = 32'h1;
    step();
    waddr  = 5'd7;
    wdata  = 32'hA5A5A5A5;
    raddr1 = 5'd7;
    raddr2 = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp7 = 32'hA5A5A5A5;
`else
    exp7 = 32'h1;
`endif
    chk("r7_same_cycle", rdata1, exp7);
    chk("r7_zero_port2", rdata2, 32'h0);
    step();
    we = 1'b0;
    #1;
    chk("r7_next_cycle", rdata1, 32'hA5A5A5A5);
    chk("r7_cnt", {16'h0, wr_count}, 32'd3);
    chk("err_sticky", {31'h0, zero_wr_err}, 32'h1);

    // Writing r0 again while port 1 reads r0 still yields zero.
    we     = 1'b1;
    waddr  = 5'd0;
    wdata  = 32'hFFFFFFFF;
    raddr1 = 5'd0;
    raddr2 = 5'd5;
    #1;
    chk("r0_wr_rd", rdata1, 32'h0);
    chk("r5_hold", rdata2, 32'hDEADBEEF);
    step();
    chk("r0_cnt2", {16'h0, wr_count}, 32'd3);

    // Reset beats a concurrent write.
    rst_n = 1'b0;
    we    = 1'b1;
    waddr = 5'd3;
    wdata = 32'hFFFFFFFF;
    step();
    rst_n  = 1'b1;
    we     = 1'b0;
    raddr1 = 5'd3;
    raddr2 = 5'd5;
    #1;
    chk("rstw_r3", rdata1, 32'h0);
    chk("rstw_r5", rdata2, 32'h0);
    chk("rstw_cnt", {16'h0, wr_count}, 32'h0);
    chk("rstw_err", {31'h0, zero_wr_err}, 32'h0);

    // Drive the counter up to saturation.
    we = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      waddr = 5'((i % 31) + 1);
      wdata = 32'(i);
      step();
    end
    chk("cnt_fffe", {16'h0, wr_count}, 32'h0000FFFE);
    waddr = 5'd9;
    wdata = 32'hCAFEF00D;
    step();
    chk("cnt_ffff", {16'h0, wr_count}, 32'h0000FFFF);
    for (int i = 0; i < 10; i++) begin
      waddr = 5'd10;
      wdata = 32'h5000 + 32'(i);
      step();
    end
    we     = 1'b0;
    raddr1 = 5'd9;
    raddr2 = 5'd10;
    #1;
    chk("cnt_hold", {16'h0, wr_count}, 32'h0000FFFF);
    chk("sat_r9", rdata1, 32'hCAFEF00D);
    chk("sat_r10", rdata2, 32'h00005009);
    chk("sat_err", {31'h0, zero_wr_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_zero.md
REGFILE_ZERO -- requirements
Module: regfile_zero

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of every register in bits.
REQ-002 SHALL have parameter DEPTH, default 32, meaning register count (power of two, >=2).
REQ-003 SHALL have derived parameter ADDR_W, default $clog2(DEPTH), meaning address width.
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_W  write address.
REQ-008 SHALL have port wdata  input  WIDTH  write data.
REQ-009 SHALL have port raddr1  input  ADDR_W  read port 1 address.
REQ-010 SHALL have port rdata1  output  WIDTH  read port 1 data.
REQ-011 SHALL have port raddr2  input  ADDR_W  read port 2 address.
REQ-012 SHALL have port rdata2  output  WIDTH  read port 2 data.
REQ-013 SHALL have port zero_wr_err  output  1  sticky flag: write to register 0 attempted.
REQ-014 SHALL have port wr_count  output  16  count of committed writes, saturating.

Function
REQ-015 Register 0 SHALL be hardwired to all-zeros of WIDTH bits; reads of address 0 return 0 on both ports at all times.
REQ-016 Writes SHALL commit on rising clk when we=1, rst_n=1 and waddr!=0; data is visible on reads from the next cycle.
REQ-017 A write with we=1, waddr=0 SHALL be discarded, SHALL set zero_wr_err on that edge and SHALL NOT increment wr_count.
REQ-018 zero_wr_err SHALL remain 1 until reset.
REQ-019 Reads SHALL be combinational: rdata1/rdata2 reflect the addressed register in the same cycle; both ports are independent and may address the same register.
REQ-020 wr_count SHALL increment by 1 per committed write and saturate at 16'hFFFF (no wrap).
REQ-021 Simultaneous write and read of the same non-zero address, without bypass, SHALL return the old value in that cycle.
REQ-022 rdata for out-of-range addresses cannot occur (DEPTH power of two); no special handling.

Reset
REQ-023 When rst_n=0 at a rising clk, all registers SHALL clear to 0, zero_wr_err to 0, wr_count to 0; any concurrent write SHALL be ignored.
REQ-024 Reset asserted mid-operation SHALL take priority over we in the same cycle; rdata follows cleared contents from the next cycle.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: a read address equal to waddr (non-zero) with we=1 and rst_n=1 SHALL return wdata in the same cycle (write-through forwarding).
REQ-026 Macro REGFILE_BYPASS_EN undefined: no forwarding; behaviour per REQ-021.
REQ-027 Address 0 SHALL read 0 irrespective of REGFILE_BYPASS_EN.

Structure
REQ-028 Package regfile_pkg SHALL hold default WIDTH, DEPTH, the zero-register index constant and the wr_count width/saturation constant.
REQ-029 One sub-module regfile_rdport SHALL implement a single read port (address decode, zero-forcing, optional bypass), instantiated twice.
REQ-030 Storage array and counters SHALL reside in the top module.

Verification
REQ-031 Reset then read all addresses on both ports -> every rdata = 0, wr_count=0, zero_wr_err=0.
REQ-032 Write 32'hDEADBEEF to r5, next cycle raddr1=5, raddr2=5 -> both rdata = 32'hDEADBEEF, wr_count=1.
REQ-033 Write 32'h12345678 to r0 -> rdata at address 0 stays 0, zero_wr_err=1 and stays 1, wr_count unchanged.
REQ-034 Same-cycle write 32'hA5A5A5A5 to r7 with raddr1=7 (r7 previously 32'h1) -> rdata1=32'h1 without REGFILE_BYPASS_EN, 32'hA5A5A5A5 with it.
REQ-035 rst_n=0 in the same cycle as we=1 to r3 with 32'hFFFFFFFF -> r3 reads 0 afterwards, wr_count=0.
REQ-036 Force 65536 committed writes -> wr_count saturates at 16'hFFFF and holds on further writes.
